// File: rtl/serial_operand_loader_pkg.sv
// Shared definitions for the serial operand loader and the comparator network
// that consumes its parallel operands.
//   state_e      : loader FSM state encoding (IDLE / LOAD / HOLD)
//   K_DEFAULT    : default operand width in bits
//   cmp_cell     : one MSB-first magnitude comparator cell
package serial_operand_loader_pkg;

  localparam int unsigned K_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Comparator cell, chained MSB to LSB. {gt,lt} from the more significant
  // bits wins; only while those are equal does this bit pair decide.
  function automatic logic [1:0] cmp_cell(input logic       a,
                                          input logic       b,
                                          input logic [1:0] gt_lt_in);
    logic [1:0] r;
    r = gt_lt_in;
    if (gt_lt_in == 2'b00) begin
      r = {a & ~b, ~a & b};
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_operand_loader_operand_shift_reg.sv
// K-bit left shift register with shift enable and synchronous clear.
//   clk : clock
//   clr : synchronous clear (wins over en)
//   en  : shift d into the LSB this cycle
//   d   : serial input bit
//   q   : parallel contents, MSB = oldest bit shifted in
module operand_shift_reg
  import serial_operand_loader_pkg::*;
#(
  parameter int unsigned K = K_DEFAULT
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         d,
  output logic [K-1:0] q
);

  logic [K-1:0] q_q;
  logic [K-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = {q_q[K-2:0], d};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_operand_loader.sv
// Serial operand loader: assembles two K-bit operands A and B from MSB-first
// bit pairs and holds them for the comparator network until consumed.
//   clk, rst      : clock, synchronous active-high reset
//   start         : pulse that begins (or restarts) a load
//   bit_valid     : a_bit/b_bit carry a valid pair this cycle
//   a_bit, b_bit  : serial operand bits, MSB first
//   in_ready      : pairs are accepted (LOAD)
//   A, B          : assembled operands
//   out_valid     : A/B complete and stable (HOLD)
//   out_ready     : downstream has consumed A/B
//   busy          : LOAD or HOLD
module serial_operand_loader
  import serial_operand_loader_pkg::*;
#(
  parameter int unsigned K = K_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         bit_valid,
  input  logic         a_bit,
  input  logic         b_bit,
  output logic         in_ready,
  output logic [K-1:0] A,
  output logic [K-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int unsigned CW = $clog2(K);
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          shift_en;

  // A start in LOAD aborts the load, so a pair arriving with it is dropped.
  assign shift_en = (state_q == ST_LOAD) && bit_valid && !start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (start) begin
          cnt_d = '0;
        end else if (bit_valid) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_HOLD: begin
        // start without out_ready is ignored; with it, go straight to LOAD.
        if (out_ready) begin
          state_d = start ? ST_LOAD : ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  operand_shift_reg #(.K(K)) u_sr_a (
    .clk (clk),
    .clr (rst),
    .en  (shift_en),
    .d   (a_bit),
    .q   (A)
  );

  operand_shift_reg #(.K(K)) u_sr_b (
    .clk (clk),
    .clr (rst),
    .en  (shift_en),
    .d   (b_bit),
    .q   (B)
  );

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_operand_loader.sv
module tb_serial_operand_loader;

  localparam int K = 5;

  logic         clk = 1'b0;
  logic         rst, start, bit_valid, a_bit, b_bit, out_ready;
  logic         in_ready, out_valid, busy;
  logic [K-1:0] A, B;

  int nvec = 0;
  int nmis = 0;

  // Behavioural reference: a count of accepted bits plus "collecting" and
  // "holding" flags, operands built with integer arithmetic.
  bit m_load, m_hold;
  int m_n, m_A, m_B;

  serial_operand_loader #(.K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit       rst, start, bv, a, b, ordy;
    bit       e_ir, e_ov, e_busy;
    bit [4:0] e_a, e_b;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit bv, input bit a,
                            input bit b, input bit ordy);
    if (r) begin
      m_load = 0; m_hold = 0; m_n = 0; m_A = 0; m_B = 0;
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 0; m_load = s; m_n = 0;
      end
    end else if (m_load) begin
      if (s) m_n = 0;
      else if (bv) begin
        m_A = (m_A * 2 + int'(a)) % (1 << K);
        m_B = (m_B * 2 + int'(b)) % (1 << K);
        m_n++;
        if (m_n == K) begin
          m_load = 0; m_hold = 1; m_n = 0;
        end
      end
    end else if (s) begin
      m_load = 1; m_n = 0;
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit bv, input bit a,
                       input bit b, input bit ordy);
    rst = r; start = s; bit_valid = bv; a_bit = a; b_bit = b; out_ready = ordy;
    @(posedge clk);
    model_edge(r, s, bv, a, b, ordy);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " in_ready"},  32'(in_ready),  32'(m_load));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(m_hold));
    chk({tag, " busy"},      32'(busy),      32'(m_load | m_hold));
    chk({tag, " A"},         32'(A),         32'(m_A));
    chk({tag, " B"},         32'(B),         32'(m_B));
  endtask

  task automatic load_word(input bit [4:0] wa, input bit [4:0] wb, input string tag);
    for (int i = K - 1; i >= 0; i--) begin
      drive(0, 0, 1, wa[i], wb[i], 0);
      check_model(tag);
    end
  endtask

  initial begin
    bit [4:0] wa, wb;
    rst = 1; start = 0; bit_valid = 0; a_bit = 0; b_bit = 0; out_ready = 0;

    // Reset state, with inputs busy to show reset overrides them.
    drive(1, 1, 1, 1, 1, 1);
    drive(1, 0, 0, 0, 0, 0);
    chk("reset in_ready", 32'(in_ready), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset A", 32'(A), 0);
    chk("reset B", 32'(B), 0);

    // Basic word a=10110 b=01111, first start right after reset.
    tbl[0] = '{0,1,0,0,0,0, 1,0,1, 5'b00000, 5'b00000};
    tbl[1] = '{0,0,1,1,0,0, 1,0,1, 5'b00001, 5'b00000};
    tbl[2] = '{0,0,1,0,1,0, 1,0,1, 5'b00010, 5'b00001};
    tbl[3] = '{0,0,1,1,1,0, 1,0,1, 5'b00101, 5'b00011};
    tbl[4] = '{0,0,1,1,1,0, 1,0,1, 5'b01011, 5'b00111};
    tbl[5] = '{0,0,1,0,1,0, 0,1,1, 5'b10110, 5'b01111};
    tbl[6] = '{0,0,1,1,0,0, 0,1,1, 5'b10110, 5'b01111};
    tbl[7] = '{0,0,0,0,0,1, 0,0,0, 5'b10110, 5'b01111};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].bv, tbl[i].a, tbl[i].b, tbl[i].ordy);
      chk($sformatf("tbl%0d in_ready", i),  32'(in_ready),  32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d busy", i),      32'(busy),      32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d A", i),         32'(A),         32'(tbl[i].e_a));
      chk($sformatf("tbl%0d B", i),         32'(B),         32'(tbl[i].e_b));
    end

    // Gapped load: same word as above with 1-3 idle cycles between pairs.
    wa = 5'b10110; wb = 5'b01111;
    drive(0, 1, 0, 0, 0, 0);
    for (int i = K - 1; i >= 0; i--) begin
      int gaps;
      gaps = int'($urandom_range(1, 3));
      for (int g = 0; g < gaps; g++) begin
        drive(0, 0, 0, 1'($urandom), 1'($urandom), 0);
        chk("gap in_ready", 32'(in_ready), 1);
        check_model("gap");
      end
      drive(0, 0, 1, wa[i], wb[i], 0);
      check_model("gap");
    end
    chk("gap A", 32'(A), 32'(5'b10110));
    chk("gap B", 32'(B), 32'(5'b01111));
    chk("gap out_valid", 32'(out_valid), 1);

    // Held 10 cycles with toggling bits and stray starts; nothing moves.
    for (int i = 0; i < 10; i++) begin
      drive(0, (i % 3) == 0, 1, i[0], ~i[0], 0);
      chk("hold A", 32'(A), 32'(5'b10110));
      chk("hold B", 32'(B), 32'(5'b01111));
      chk("hold out_valid", 32'(out_valid), 1);
      chk("hold in_ready", 32'(in_ready), 0);
    end
    drive(0, 0, 0, 0, 0, 1);
    chk("release out_valid", 32'(out_valid), 0);
    chk("release busy", 32'(busy), 0);
    check_model("release");

    // Abort after 3 pairs; a start cycle also carrying a pair discards it.
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 1, 0);
    drive(0, 0, 1, 0, 1, 0);
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 1, 0);
    chk("abort in_ready", 32'(in_ready), 1);
    check_model("abort");
    load_word(5'b11001, 5'b00110, "abort");
    chk("abort A", 32'(A), 32'(5'b11001));
    chk("abort B", 32'(B), 32'(5'b00110));
    chk("abort out_valid", 32'(out_valid), 1);

    // Back-to-back: out_ready and start together in HOLD.
    drive(0, 1, 0, 0, 0, 1);
    chk("b2b in_ready", 32'(in_ready), 1);
    chk("b2b out_valid", 32'(out_valid), 0);
    load_word(5'b11111, 5'b00000, "b2b");
    chk("b2b A", 32'(A), 32'(5'b11111));
    chk("b2b B", 32'(B), 32'(5'b00000));
    chk("b2b out_valid", 32'(out_valid), 1);
    drive(0, 0, 0, 0, 0, 1);

    // Reset in the middle of a load, then a full load.
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 1, 0);
    drive(0, 0, 1, 0, 1, 0);
    drive(1, 0, 1, 1, 1, 0);
    chk("midrst in_ready", 32'(in_ready), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst A", 32'(A), 0);
    chk("midrst B", 32'(B), 0);
    drive(0, 1, 0, 0, 0, 0);
    load_word(5'b01101, 5'b10010, "postrst");
    chk("postrst A", 32'(A), 32'(5'b01101));
    chk("postrst out_valid", 32'(out_valid), 1);
    drive(0, 0, 0, 0, 0, 1);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
            1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
